mmc_rd_burst_buf: RTL and testbench

Per-channel read-return buffer in the main memory controller, directly downstream of the DFI DDR-to-SDR return path. It accepts beats on the dfi__mmc__valid/cntl/data interface, checks SOM/MOM/EOM framing against the configured burst size, and stores beats in a burst-granular FIFO. It drains to the MRC over a valid/ready interface, and it issues read credits to the MMC command sequencer so that no issued read can overflow the buffer.

---
 rtl/mmc_rd_burst_buf.sv | 193 +++++++++++++++++++
 tb/tb_mmc_rd_burst_buf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_rd_burst_buf.sv
// Read-return buffer: frames DFI return beats into whole bursts, buffers them, drains to MRC, issues read credits.
// Latency: EOM accepted in cycle N -> first beat of that burst valid at N+2; output held stable while valid && !ready.
module mmc_rd_burst_buf #(
    parameter int NUM_WORDS    = 4,
    parameter int WORD_WIDTH   = 32,
    parameter int BURST_SIZE   = 2,
    parameter int DEPTH_BURSTS = 4,
    parameter int CNTL_WIDTH   = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_poweron,
    input  logic                                   dfi__mmc__valid,
    input  logic [CNTL_WIDTH-1:0]                  dfi__mmc__cntl,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0]        dfi__mmc__data,
    input  logic                                   seq__rdb__rd_issue,
    output logic                                   rdb__seq__rd_credit,
    output logic                                   mmc__mrc__valid,
    output logic [CNTL_WIDTH-1:0]                  mmc__mrc__cntl,
    output logic [NUM_WORDS*WORD_WIDTH-1:0]        mmc__mrc__data,
    input  logic                                   mrc__mmc__ready,
    output logic [$clog2(DEPTH_BURSTS+1)-1:0]      rdb__sts__outstanding,
    output logic                                   rdb__sts__frame_err,
    output logic                                   rdb__sts__unexp_err
);
    localparam int DW    = NUM_WORDS * WORD_WIDTH;
    localparam int DEPTH = DEPTH_BURSTS * BURST_SIZE;
    localparam int PW    = $clog2(DEPTH);
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int OW    = $clog2(DEPTH_BURSTS + 1);
    localparam int BW    = $clog2(BURST_SIZE + 1);

    localparam logic [CNTL_WIDTH-1:0] TAG_MOM     = CNTL_WIDTH'(0);
    localparam logic [CNTL_WIDTH-1:0] TAG_SOM     = CNTL_WIDTH'(1);
    localparam logic [CNTL_WIDTH-1:0] TAG_EOM     = CNTL_WIDTH'(2);
    localparam logic [CNTL_WIDTH-1:0] TAG_SOM_EOM = CNTL_WIDTH'(3);
    localparam logic [OW-1:0]         ONE_O       = OW'(1);

    typedef enum logic {S_IDLE, S_IN_BURST} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        bc_q, bc_d, obc_q, obc_d;
    logic [PW-1:0]        wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d;
    logic [AW-1:0]        avail_q, avail_d;
    logic [OW-1:0]        out_cnt_q, out_cnt_d, bursts_q, bursts_d;
    logic [OW:0]          rsv_d;
    logic                 credit_q, credit_d;
    logic                 out_vld_q, out_vld_d, ferr_q, ferr_d, unexp_q, unexp_d;
    logic [CNTL_WIDTH-1:0] out_cntl_q, out_cntl_d;
    logic [DW-1:0]        out_dat_q, out_dat_d;
    logic [DW-1:0]        mem_q [DEPTH];

    logic beat_vld, wr_en, commit, rollback, ferr_beat, issue_ok, pop, pop_last;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CNTL_WIDTH-1:0] tag_of(input logic [BW-1:0] idx);
        if (BURST_SIZE == 1) return TAG_SOM_EOM;
        if (idx == '0) return TAG_SOM;
        if (idx == BW'(BURST_SIZE - 1)) return TAG_EOM;
        return TAG_MOM;
    endfunction

    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        wr_en     = 1'b0;
        commit    = 1'b0;
        rollback  = 1'b0;
        ferr_beat = 1'b0;
        // Beats with nothing outstanding are dropped before the framing decode.
        beat_vld  = dfi__mmc__valid && (out_cnt_q != '0);
        if (beat_vld) begin
            case (state_q)
                S_IDLE: begin
                    if (BURST_SIZE == 1 && dfi__mmc__cntl == TAG_SOM_EOM) begin
                        wr_en  = 1'b1;
                        commit = 1'b1;
                    end else if (BURST_SIZE > 1 && dfi__mmc__cntl == TAG_SOM) begin
                        wr_en   = 1'b1;
                        bc_d    = BW'(1);
                        state_d = S_IN_BURST;
                    end else begin
                        ferr_beat = 1'b1;
                    end
                end
                S_IN_BURST: begin
                    if (dfi__mmc__cntl == TAG_MOM && bc_q < BW'(BURST_SIZE - 1)) begin
                        wr_en = 1'b1;
                        bc_d  = bc_q + BW'(1);
                    end else if (dfi__mmc__cntl == TAG_EOM && bc_q == BW'(BURST_SIZE - 1)) begin
                        wr_en   = 1'b1;
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_beat = 1'b1;
                        rollback  = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        issue_ok = seq__rdb__rd_issue && credit_q;
        pop      = (avail_q != '0) && (!out_vld_q || mrc__mmc__ready);
        pop_last = pop && (obc_q == BW'(BURST_SIZE - 1));

        // A partial burst is discarded by rewinding to the last committed boundary.
        wr_d  = rollback ? cmt_q : (wr_en ? inc_ptr(wr_q) : wr_q);
        cmt_d = commit ? inc_ptr(wr_q) : cmt_q;
        rd_d  = pop ? inc_ptr(rd_q) : rd_q;
        obc_d = pop ? (pop_last ? '0 : obc_q + BW'(1)) : obc_q;
        avail_d = avail_q + (commit ? AW'(BURST_SIZE) : '0) - (pop ? AW'(1) : '0);

        case ({issue_ok, commit})
            2'b10:   out_cnt_d = out_cnt_q + ONE_O;
            2'b01:   out_cnt_d = out_cnt_q - ONE_O;
            default: out_cnt_d = out_cnt_q;
        endcase

        bursts_d = bursts_q;
        if (wr_en && state_q == S_IDLE) bursts_d = bursts_d + ONE_O;
        if (rollback)                   bursts_d = bursts_d - ONE_O;
        if (pop_last)                   bursts_d = bursts_d - ONE_O;

        rsv_d    = {1'b0, out_cnt_d} + {1'b0, bursts_d};
        credit_d = rsv_d < (OW + 1)'(DEPTH_BURSTS);

        out_vld_d  = out_vld_q;
        out_cntl_d = out_cntl_q;
        out_dat_d  = out_dat_q;
        if (pop) begin
            out_vld_d  = 1'b1;
            out_cntl_d = tag_of(obc_q);
            out_dat_d  = mem_q[rd_q];
        end else if (mrc__mmc__ready) begin
            out_vld_d = 1'b0;
        end

        ferr_d  = ferr_q || ferr_beat || (seq__rdb__rd_issue && !credit_q);
        unexp_d = unexp_q || (dfi__mmc__valid && out_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= dfi__mmc__data;
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q    <= S_IDLE;
            bc_q       <= '0;
            obc_q      <= '0;
            wr_q       <= '0;
            cmt_q      <= '0;
            rd_q       <= '0;
            avail_q    <= '0;
            out_cnt_q  <= '0;
            bursts_q   <= '0;
            credit_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_cntl_q <= '0;
            out_dat_q  <= '0;
            ferr_q     <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            obc_q      <= obc_d;
            wr_q       <= wr_d;
            cmt_q      <= cmt_d;
            rd_q       <= rd_d;
            avail_q    <= avail_d;
            out_cnt_q  <= out_cnt_d;
            bursts_q   <= bursts_d;
            credit_q   <= credit_d;
            out_vld_q  <= out_vld_d;
            out_cntl_q <= out_cntl_d;
            out_dat_q  <= out_dat_d;
            ferr_q     <= ferr_d;
            unexp_q    <= unexp_d;
        end
    end

    assign rdb__seq__rd_credit   = credit_q;
    assign mmc__mrc__valid       = out_vld_q;
    assign mmc__mrc__cntl        = out_cntl_q;
    assign mmc__mrc__data        = out_dat_q;
    assign rdb__sts__outstanding = out_cnt_q;
    assign rdb__sts__frame_err   = ferr_q;
    assign rdb__sts__unexp_err   = unexp_q;
endmodule

// File: tb/tb_mmc_rd_burst_buf.sv
// Testbench for mmc_rd_burst_buf: directed scenarios plus randomized beats against a queue-based model.
module tb_mmc_rd_burst_buf;
    localparam int NW = 4, WWID = 32, BS = 2, DB = 4, CW = 2;
    localparam int DW = NW * WWID;
    localparam logic [CW-1:0] MOM = 2'd0, SOM = 2'd1, EOM = 2'd2, SOM_EOM = 2'd3;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_vld = 1'b0, rd_issue = 1'b0, ready = 1'b0;
    logic [CW-1:0] in_cntl = '0;
    logic [DW-1:0] in_dat = '0;
    logic          credit, out_vld, ferr, unexp;
    logic [CW-1:0] out_cntl;
    logic [DW-1:0] out_dat;
    logic [2:0]    outstanding;

    int n_checks = 0, n_errors = 0, cyc_cnt = 0, rdy_mode = 0;
    int m_out = 0, m_bc = 0;
    bit m_inb = 0, m_ferr = 0, m_unexp = 0;
    logic [DW-1:0]    m_part[$];
    logic [CW+DW-1:0] exp_q[$];
    int               acc_cyc[$];
    bit               hold_vld = 0;
    logic [CW+DW-1:0] hold_dat = '0;

    mmc_rd_burst_buf #(.NUM_WORDS(NW), .WORD_WIDTH(WWID), .BURST_SIZE(BS),
                       .DEPTH_BURSTS(DB), .CNTL_WIDTH(CW)) dut (
        .clk(clk), .reset_poweron(rst),
        .dfi__mmc__valid(in_vld), .dfi__mmc__cntl(in_cntl), .dfi__mmc__data(in_dat),
        .seq__rdb__rd_issue(rd_issue), .rdb__seq__rd_credit(credit),
        .mmc__mrc__valid(out_vld), .mmc__mrc__cntl(out_cntl), .mmc__mrc__data(out_dat),
        .mrc__mmc__ready(ready), .rdb__sts__outstanding(outstanding),
        .rdb__sts__frame_err(ferr), .rdb__sts__unexp_err(unexp));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer: random or forced ready, checks every accepted beat and hold stability.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 0;
        end else begin
            if (hold_vld) begin
                check("hold_vld", out_vld, 1);
                check("hold_dat", {out_cntl, out_dat}, hold_dat);
            end
            if (out_vld && ready) begin
                check("exp_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("out_beat", {out_cntl, out_dat}, exp_q.pop_front());
                acc_cyc.push_back(cyc_cnt);
            end
            hold_vld = out_vld && !ready;
            hold_dat = {out_cntl, out_dat};
        end
    end

    function automatic int m_reserved();
        return m_out + (exp_q.size() + BS - 1) / BS + int'(m_inb);
    endfunction

    function automatic logic [CW-1:0] good_tag();
        if (!m_inb) return (BS == 1) ? SOM_EOM : SOM;
        return (m_bc == BS - 1) ? EOM : MOM;
    endfunction

    task automatic m_commit();
        for (int i = 0; i < m_part.size(); i++)
            exp_q.push_back({(BS == 1) ? SOM_EOM : (i == 0) ? SOM : (i == BS - 1) ? EOM : MOM, m_part[i]});
        m_part.delete();
        m_out--;
    endtask

    task automatic m_beat(input logic [CW-1:0] c, input logic [DW-1:0] d);
        if (m_out == 0) m_unexp = 1;
        else if (!m_inb) begin
            if (BS == 1 && c == SOM_EOM) begin m_part = {d}; m_commit(); end
            else if (BS > 1 && c == SOM) begin m_part = {d}; m_inb = 1; m_bc = 1; end
            else m_ferr = 1;
        end else begin
            if (c == MOM && m_bc < BS - 1) begin m_part.push_back(d); m_bc++; end
            else if (c == EOM && m_bc == BS - 1) begin m_part.push_back(d); m_commit(); m_inb = 0; end
            else begin m_ferr = 1; m_part.delete(); m_inb = 0; end
        end
    endtask

    task automatic cyc(input bit iss, input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        int res;
        res = m_reserved();
        rd_issue = iss; in_vld = v; in_cntl = c; in_dat = d;
        if (v) m_beat(c, d);
        if (iss) begin
            if (res < DB) m_out++;
            else m_ferr = 1;
        end
        @(posedge clk); #1;
        rd_issue = 0; in_vld = 0; in_cntl = '0; in_dat = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, '0, '0);
    endtask

    function automatic logic [DW-1:0] rnd_dat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_vld) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        check("drain_in_time", t < 500, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        m_out = 0; m_bc = 0; m_inb = 0; m_ferr = 0; m_unexp = 0;
        m_part.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", out_vld, 0);
        check("rst_credit", credit, 0);
        check("rst_outst", outstanding, 0);
        check("rst_ferr", ferr, 0);
        check("rst_unexp", unexp, 0);
        check("rst_cntl", out_cntl, 0);
        check("rst_dat", out_dat, 0);
        @(posedge clk); #1;
        rst = 0;
        idle(3);
        check("post_rst_credit", credit, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0, d1;
        int base, eom_cyc, t, k, m;
        @(posedge clk); #1;
        do_reset();

        // Single burst, ready high: SOM then EOM on consecutive cycles, N+2 latency.
        rdy_mode = 1; idle(2);
        acc_cyc.delete();
        d0 = {4{32'h1111_1111}}; d1 = {4{32'h2222_2222}};
        cyc(1, 0, '0, '0);
        check("t1_outst_1", outstanding, m_out);
        cyc(0, 1, SOM, d0);
        cyc(0, 1, EOM, d1);
        eom_cyc = cyc_cnt;
        check("t1_outst_0", outstanding, 0);
        check("t1_credit", credit, 1);
        wait_drain();
        check("t1_n_acc", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) begin
            check("t1_latency", acc_cyc[0] - eom_cyc, 1);
            check("t1_consec", acc_cyc[1] - acc_cyc[0], 1);
        end

        // Fill all credits with ready low, refused fifth issue, then drain.
        rdy_mode = 0; idle(2);
        for (int i = 0; i < DB; i++) cyc(1, 0, '0, '0);
        check("t2_credit_full", credit, m_reserved() < DB);
        check("t2_outst_4", outstanding, 4);
        cyc(1, 0, '0, '0);
        check("t2_ferr_issue", ferr, m_ferr);
        check("t2_outst_still4", outstanding, m_out);
        for (int i = 0; i < DB; i++) begin
            cyc(0, 1, SOM, rnd_dat());
            cyc(0, 1, EOM, rnd_dat());
        end
        check("t2_outst_0", outstanding, 0);
        check("t2_credit_stored", credit, m_reserved() < DB);
        base = acc_cyc.size();
        rdy_mode = 1;
        t = 0;
        while (acc_cyc.size() < base + BS && t < 100) begin idle(1); t++; end
        check("t2_first_burst_out", t < 100, 1);
        idle(2);
        check("t2_credit_back", credit, 1);
        wait_drain();
        check("t2_credit_end", credit, m_reserved() < DB);
        do_reset();

        // Missing EOM: partial burst discarded, following clean burst delivered.
        rdy_mode = 1;
        cyc(1, 0, '0, '0);
        cyc(0, 1, SOM, {4{32'hAAAA_0001}});
        cyc(0, 1, SOM, {4{32'hAAAA_0002}});
        check("t3_ferr", ferr, m_ferr);
        cyc(0, 1, SOM, {4{32'hBBBB_0001}});
        cyc(0, 1, EOM, {4{32'hBBBB_0002}});
        wait_drain();
        check("t3_outst", outstanding, m_out);
        check("t3_unexp", unexp, 0);
        do_reset();

        // Beat with nothing outstanding.
        rdy_mode = 1;
        cyc(0, 1, SOM, rnd_dat());
        check("t4_unexp", unexp, m_unexp);
        check("t4_ferr", ferr, 0);
        idle(4);
        check("t4_no_out", out_vld, 0);
        cyc(1, 0, '0, '0);
        cyc(0, 1, SOM, rnd_dat());
        cyc(0, 1, EOM, rnd_dat());
        wait_drain();
        do_reset();

        // Issue coincident with EOM keeps outstanding unchanged.
        rdy_mode = 1;
        cyc(1, 0, '0, '0);
        cyc(0, 1, SOM, rnd_dat());
        cyc(1, 1, EOM, rnd_dat());
        check("t5_outst_same", outstanding, 1);
        cyc(0, 1, SOM, rnd_dat());
        cyc(0, 1, EOM, rnd_dat());
        wait_drain();
        check("t5_outst_0", outstanding, m_out);

        // Reset mid-burst: no stale beats afterwards.
        cyc(1, 0, '0, '0);
        cyc(0, 1, SOM, {4{32'hDEAD_BEEF}});
        do_reset();
        rdy_mode = 1;
        cyc(1, 0, '0, '0);
        cyc(0, 1, SOM, rnd_dat());
        cyc(0, 1, EOM, rnd_dat());
        wait_drain();
        check("t6_outst", outstanding, 0);

        // Randomized traffic with mostly-legal framing and random backpressure.
        do_reset();
        rdy_mode = 2;
        for (int it = 0; it < 60; it++) begin
            wait_drain();
            idle(2);
            check("rnd_credit", credit, m_reserved() < DB);
            check("rnd_outst", outstanding, m_out);
            k = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) cyc(1, 0, '0, '0);
            m = $urandom_range(1, 5);
            for (int i = 0; i < m; i++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                if ($urandom_range(0, 7) < 6) cyc(0, 1, good_tag(), rnd_dat());
                else cyc(0, 1, CW'($urandom_range(0, 3)), rnd_dat());
            end
            check("rnd_ferr", ferr, m_ferr);
            check("rnd_unexp", unexp, m_unexp);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
